// File: rtl/eth_tx_arbiter.sv
// Two-requester, frame-granular AXI-Stream arbiter in front of the Ethernet MAC TX.
// Truncates frames longer than MAX_BEATS. Define ETH_TX_ARB_STRICT_PRIO_EN for strict req0 priority.
module eth_tx_arbiter #(
  parameter int MAX_BEATS  = 191,
  parameter int IFG_CYCLES = 2
) (
  input  logic        clock,
  input  logic        async_resetn,
  input  logic [63:0] req0_axis_tdata,
  input  logic [7:0]  req0_axis_tkeep,
  input  logic        req0_axis_tlast,
  input  logic        req0_axis_tuser,
  input  logic        req0_axis_tvalid,
  output logic        req0_axis_tready,
  input  logic [63:0] req1_axis_tdata,
  input  logic [7:0]  req1_axis_tkeep,
  input  logic        req1_axis_tlast,
  input  logic        req1_axis_tuser,
  input  logic        req1_axis_tvalid,
  output logic        req1_axis_tready,
  output logic [63:0] tx_axis_tdata,
  output logic [7:0]  tx_axis_tkeep,
  output logic        tx_axis_tlast,
  output logic        tx_axis_tuser,
  output logic        tx_axis_tvalid,
  input  logic        tx_axis_tready,
  output logic [1:0]  grant,
  output logic [15:0] trunc_count
);

  localparam int CNT_W = ($clog2(MAX_BEATS) > 8) ? $clog2(MAX_BEATS) : 8;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BEATS - 1);
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP, S_GAP} state_t;
  localparam state_t END_STATE = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;

  state_t           r_state;
  logic [1:0]       r_grant;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [15:0]      r_trunc_cnt;
  logic             r_last_gnt;
  logic [GAP_W-1:0] r_gap_cnt;

  logic [63:0] w_own_tdata;
  logic [7:0]  w_own_tkeep;
  logic        w_own_tlast;
  logic        w_own_tuser;
  logic        w_own_tvalid;
  logic        w_own_sel;
  logic        w_own_rdy;
  logic        w_trunc;
  logic        w_accept;
  logic        w_drop_acc;
  logic        w_pick1;

  // Owner mux: grant[1] selects requester 1, otherwise requester 0.
  assign w_own_sel    = r_grant[1];
  assign w_own_tdata  = w_own_sel ? req1_axis_tdata  : req0_axis_tdata;
  assign w_own_tkeep  = w_own_sel ? req1_axis_tkeep  : req0_axis_tkeep;
  assign w_own_tlast  = w_own_sel ? req1_axis_tlast  : req0_axis_tlast;
  assign w_own_tuser  = w_own_sel ? req1_axis_tuser  : req0_axis_tuser;
  assign w_own_tvalid = w_own_sel ? req1_axis_tvalid : req0_axis_tvalid;

  assign w_trunc    = (r_beat_cnt == BEAT_LAST) && !w_own_tlast;
  assign w_accept   = (r_state == S_PASS) && w_own_tvalid && tx_axis_tready;
  assign w_drop_acc = (r_state == S_DROP) && w_own_tvalid;

`ifdef ETH_TX_ARB_STRICT_PRIO_EN
  assign w_pick1 = req1_axis_tvalid && !req0_axis_tvalid;
`else
  // Round-robin: on contention, requester 1 wins only if requester 0 went last.
  assign w_pick1 = req1_axis_tvalid && (!req0_axis_tvalid || !r_last_gnt);
`endif

  always_comb begin
    tx_axis_tdata  = '0;
    tx_axis_tkeep  = '0;
    tx_axis_tlast  = 1'b0;
    tx_axis_tuser  = 1'b0;
    tx_axis_tvalid = 1'b0;
    w_own_rdy      = 1'b0;
    if (r_state == S_PASS) begin
      tx_axis_tdata  = w_own_tdata;
      tx_axis_tkeep  = w_own_tkeep;
      tx_axis_tlast  = w_own_tlast | w_trunc;
      tx_axis_tuser  = w_own_tuser | w_trunc;
      tx_axis_tvalid = w_own_tvalid;
      w_own_rdy      = tx_axis_tready;
    end else if (r_state == S_DROP) begin
      w_own_rdy = 1'b1;
    end
  end

  assign req0_axis_tready = w_own_rdy & r_grant[0];
  assign req1_axis_tready = w_own_rdy & r_grant[1];
  assign grant            = r_grant;
  assign trunc_count      = r_trunc_cnt;

  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      r_state     <= S_IDLE;
      r_grant     <= 2'b00;
      r_beat_cnt  <= '0;
      r_trunc_cnt <= '0;
      r_last_gnt  <= 1'b1;
      r_gap_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0_axis_tvalid || req1_axis_tvalid) begin
            r_grant <= w_pick1 ? 2'b10 : 2'b01;
            r_state <= S_PASS;
          end
        end
        S_PASS: begin
          if (w_accept) begin
            if (w_own_tlast) begin
              r_last_gnt <= w_own_sel;
              r_grant    <= 2'b00;
              r_beat_cnt <= '0;
              r_state    <= END_STATE;
            end else if (w_trunc) begin
              if (r_trunc_cnt != 16'hFFFF) r_trunc_cnt <= r_trunc_cnt + 16'd1;
              r_beat_cnt <= '0;
              r_state    <= S_DROP;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        S_DROP: begin
          // Grant is held so the owner keeps draining until its own tlast.
          if (w_drop_acc && w_own_tlast) begin
            r_last_gnt <= w_own_sel;
            r_grant    <= 2'b00;
            r_state    <= END_STATE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter (default build: round-robin, MAX_BEATS=191, IFG_CYCLES=2).
module tb_eth_tx_arbiter;

  logic        clock = 1'b0;
  logic        async_resetn;
  logic [63:0] req0_axis_tdata, req1_axis_tdata;
  logic [7:0]  req0_axis_tkeep, req1_axis_tkeep;
  logic        req0_axis_tlast, req0_axis_tuser, req0_axis_tvalid, req0_axis_tready;
  logic        req1_axis_tlast, req1_axis_tuser, req1_axis_tvalid, req1_axis_tready;
  logic [63:0] tx_axis_tdata;
  logic [7:0]  tx_axis_tkeep;
  logic        tx_axis_tlast, tx_axis_tuser, tx_axis_tvalid, tx_axis_tready;
  logic [1:0]  grant;
  logic [15:0] trunc_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  eth_tx_arbiter #(.MAX_BEATS(191), .IFG_CYCLES(2)) dut (
    .clock(clock), .async_resetn(async_resetn),
    .req0_axis_tdata(req0_axis_tdata), .req0_axis_tkeep(req0_axis_tkeep),
    .req0_axis_tlast(req0_axis_tlast), .req0_axis_tuser(req0_axis_tuser),
    .req0_axis_tvalid(req0_axis_tvalid), .req0_axis_tready(req0_axis_tready),
    .req1_axis_tdata(req1_axis_tdata), .req1_axis_tkeep(req1_axis_tkeep),
    .req1_axis_tlast(req1_axis_tlast), .req1_axis_tuser(req1_axis_tuser),
    .req1_axis_tvalid(req1_axis_tvalid), .req1_axis_tready(req1_axis_tready),
    .tx_axis_tdata(tx_axis_tdata), .tx_axis_tkeep(tx_axis_tkeep),
    .tx_axis_tlast(tx_axis_tlast), .tx_axis_tuser(tx_axis_tuser),
    .tx_axis_tvalid(tx_axis_tvalid), .tx_axis_tready(tx_axis_tready),
    .grant(grant), .trunc_count(trunc_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All outputs quiet: IDLE, GAP, reset.
  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {59'd0, tx_axis_tvalid, tx_axis_tlast, tx_axis_tuser, req0_axis_tready, req1_axis_tready}, 64'd0);
    chk({tag, "_grant"}, {62'd0, grant}, 64'd0);
    chk({tag, "_data"}, tx_axis_tdata, 64'd0);
    chk({tag, "_keep"}, {56'd0, tx_axis_tkeep}, 64'd0);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    async_resetn     = 1'b0;
    tx_axis_tready   = 1'b1;
    req0_axis_tdata  = '0; req0_axis_tkeep = 8'hFF; req0_axis_tlast = 0;
    req0_axis_tuser  = 0;  req0_axis_tvalid = 0;
    req1_axis_tdata  = '0; req1_axis_tkeep = 8'hFF; req1_axis_tlast = 0;
    req1_axis_tuser  = 0;  req1_axis_tvalid = 0;
    #3;
    chk_quiet("reset");
    chk("reset_trunc", {48'd0, trunc_count}, 64'd0);
    tick; tick;
    async_resetn = 1'b1;

    // Round-robin alternation with 3-beat frames
    req0_axis_tvalid = 1; req0_axis_tdata = 64'hA0;
    req1_axis_tvalid = 1; req1_axis_tdata = 64'hB0;
    #1 chk_quiet("rr_idle");
    tick;
    chk("rr_g0", {62'd0, grant}, 64'd1);
    chk("rr_v0", {63'd0, tx_axis_tvalid}, 64'd1);
    chk("rr_d0", tx_axis_tdata, 64'hA0);
    chk("rr_rdy0", {62'd0, req0_axis_tready, req1_axis_tready}, 64'b10);
    tick; req0_axis_tdata = 64'hA1;
    #1 chk("rr_d1", tx_axis_tdata, 64'hA1);
    tick; req0_axis_tdata = 64'hA2; req0_axis_tlast = 1; req0_axis_tkeep = 8'h0F;
    #1 chk("rr_last", {62'd0, tx_axis_tlast, tx_axis_tuser}, 64'b10);
    chk("rr_keep", {56'd0, tx_axis_tkeep}, 64'h0F);
    tick; req0_axis_tdata = 64'hA0; req0_axis_tlast = 0; req0_axis_tkeep = 8'hFF;
    #1 chk_quiet("rr_gap1");
    tick; chk_quiet("rr_gap2");
    tick; chk_quiet("rr_arb");
    tick;
    chk("rr_g1", {62'd0, grant}, 64'd2);
    chk("rr_d1_0", tx_axis_tdata, 64'hB0);
    chk("rr_rdy1", {62'd0, req0_axis_tready, req1_axis_tready}, 64'b01);
    tick; req1_axis_tdata = 64'hB1;
    tick; req1_axis_tdata = 64'hB2; req1_axis_tlast = 1;
    #1 chk("rr_d1_2", tx_axis_tdata, 64'hB2);
    tick; req1_axis_tvalid = 0; req1_axis_tlast = 0;
    #1 chk_quiet("rr_gap3");
    tick; tick; tick;
    chk("rr_g2", {62'd0, grant}, 64'd1);
    chk("rr_d2", tx_axis_tdata, 64'hA0);
    tick; req0_axis_tdata = 64'hA1;
    tick; req0_axis_tdata = 64'hA2; req0_axis_tlast = 1;
    tick; req0_axis_tvalid = 0; req0_axis_tlast = 0;
    tick; tick;

    // Back-pressure: tready alternates during a 4-beat frame
    req0_axis_tvalid = 1; req0_axis_tdata = 64'h10;
    tick;
    for (int k = 0; k < 4; k++) begin
      tx_axis_tready = 0; req0_axis_tdata = 64'h10 + 64'(k); req0_axis_tlast = (k == 3);
      #1 chk("bp_rdy_lo", {62'd0, req0_axis_tready, req1_axis_tready}, 64'b00);
      chk("bp_data_lo", tx_axis_tdata, 64'h10 + 64'(k));
      tick;
      tx_axis_tready = 1;
      #1 chk("bp_rdy_hi", {62'd0, req0_axis_tready, req1_axis_tready}, 64'b10);
      chk("bp_data_hi", tx_axis_tdata, 64'h10 + 64'(k));
      tick;
    end
    req0_axis_tvalid = 0; req0_axis_tlast = 0;
    #1 chk_quiet("bp_gap");
    tick; tick;

    // Exactly MAX_BEATS beats: passes unmodified
    req0_axis_tvalid = 1; req0_axis_tdata = 0;
    tick;
    for (int i = 0; i < 191; i++) begin
      req0_axis_tdata = 64'(i); req0_axis_tlast = (i == 190);
      #1 chk("x191_data", tx_axis_tdata, 64'(i));
      if (i == 190) chk("x191_last", {62'd0, tx_axis_tlast, tx_axis_tuser}, 64'b10);
      tick;
    end
    req0_axis_tvalid = 0; req0_axis_tlast = 0;
    #1 chk_quiet("x191_gap");
    chk("x191_trunc", {48'd0, trunc_count}, 64'd0);
    tick; tick;

    // 200-beat frame: truncated at beat 191, remainder dropped
    req0_axis_tvalid = 1; req0_axis_tdata = 0;
    tick;
    for (int i = 0; i < 200; i++) begin
      req0_axis_tdata = 64'(i); req0_axis_tlast = (i == 199);
      #1;
      if (i <= 190) begin
        chk("x200_vld", {63'd0, tx_axis_tvalid}, 64'd1);
        chk("x200_data", tx_axis_tdata, 64'(i));
        if (i == 189) chk("x200_pre", {62'd0, tx_axis_tlast, tx_axis_tuser}, 64'b00);
        if (i == 190) chk("x200_force", {62'd0, tx_axis_tlast, tx_axis_tuser}, 64'b11);
      end else begin
        chk("x200_drop_vld", {63'd0, tx_axis_tvalid}, 64'd0);
        chk("x200_drop_rdy", {62'd0, req0_axis_tready, req1_axis_tready}, 64'b10);
        if (i == 191) chk("x200_trunc_inc", {48'd0, trunc_count}, 64'd1);
      end
      tick;
    end
    req0_axis_tvalid = 0; req0_axis_tlast = 0;
    #1 chk_quiet("x200_gap");
    chk("x200_trunc", {48'd0, trunc_count}, 64'd1);
    tick; tick;

    // Reset at beat 2 of 5, then re-arbitration from IDLE
    req0_axis_tvalid = 1; req0_axis_tdata = 64'h50;
    tick;
    tick; req0_axis_tdata = 64'h51;
    tick; req0_axis_tdata = 64'h52;
    #1 chk("rst_pre_data", tx_axis_tdata, 64'h52);
    async_resetn = 0;
    req1_axis_tvalid = 1; req1_axis_tdata = 64'h60;
    #1 chk_quiet("rst_mid");
    chk("rst_mid_trunc", {48'd0, trunc_count}, 64'd0);
    tick; tick;
    async_resetn = 1; req0_axis_tdata = 64'h50;
    #1 chk_quiet("rst_idle");
    tick;
    chk("rst_rearb_grant", {62'd0, grant}, 64'd1);
    chk("rst_rearb_data", tx_axis_tdata, 64'h50);

    // Owner stalls mid-frame: PASS held, no re-arbitration
    tick; req0_axis_tvalid = 0;
    #1 chk("stall_vld", {63'd0, tx_axis_tvalid}, 64'd0);
    tick; tick;
    chk("stall_grant", {62'd0, grant}, 64'd1);
    chk("stall_rdy1", {63'd0, req1_axis_tready}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_arbiter.md
ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_BEATS, default 191, max accepted beats per frame (1522 B / 8 B rounded up).
REQ-002 SHALL have parameter IFG_CYCLES, default 2, idle cycles forced between granted frames (0 = none).
REQ-003 SHALL have port clock  in  1  single clock, all logic rising-edge.
REQ-004 SHALL have port async_resetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports req0_axis_tdata/tkeep/tlast/tuser/tvalid  in  64/8/1/1/1  requester 0 AXI-Stream slave (DMA TX path).
REQ-006 SHALL have port req0_axis_tready  out  1  requester 0 ready.
REQ-007 SHALL have ports req1_axis_tdata/tkeep/tlast/tuser/tvalid  in  64/8/1/1/1  requester 1 AXI-Stream slave (control-frame generator).
REQ-008 SHALL have port req1_axis_tready  out  1  requester 1 ready.
REQ-009 SHALL have ports tx_axis_tdata/tkeep/tlast/tuser/tvalid  out  64/8/1/1/1  master stream to the MAC TX.
REQ-010 SHALL have port tx_axis_tready  in  1  MAC ready.
REQ-011 SHALL have port grant  out  2  one-hot current owner (00 = none).
REQ-012 SHALL have port trunc_count  out  16  saturating count of truncated frames.

Function
REQ-013 SHALL implement states IDLE, PASS, DROP, GAP, frame-granular: owner never changes until its tlast beat is accepted.
REQ-014 IDLE: tx_axis_tvalid=0, tx_axis_tdata/tkeep/tlast/tuser=0, both treadys=0, grant=00.
REQ-015 IDLE with any reqN_axis_tvalid=1 SHALL register the winner into grant and enter PASS next cycle (one-cycle arbitration latency).
REQ-016 Both valid in IDLE SHALL grant the requester not granted last (round-robin); single valid SHALL grant that requester.
REQ-017 PASS SHALL connect the owner combinationally: tx_axis_* = owner's tdata/tkeep/tlast/tuser/tvalid, owner tready = tx_axis_tready, other tready=0.
REQ-018 A beat is accepted when tx_axis_tvalid and tx_axis_tready are both 1; the 8-bit-minimum beat counter SHALL increment per accepted beat and clear on leaving PASS.
REQ-019 Accepted beat with tlast=1 SHALL record the owner as last-granted and go to GAP if IFG_CYCLES>0, else IDLE.
REQ-020 Accepted beat number MAX_BEATS (counter = MAX_BEATS-1) with owner tlast=0 SHALL be output with tlast=1 and tuser=1 forced, increment trunc_count (saturating at 0xFFFF), and enter DROP.
REQ-021 Beat number MAX_BEATS with owner tlast=1 SHALL pass unmodified (no truncation).
REQ-022 DROP: tx_axis_tvalid=0, owner tready=1, discard owner beats until its tlast beat is accepted, then GAP/IDLE per REQ-019.
REQ-023 GAP: all outputs as IDLE, count IFG_CYCLES cycles, then IDLE; requests during GAP SHALL wait.
REQ-024 Owner deasserting tvalid mid-frame SHALL hold PASS (no re-arbitration, tx_axis_tvalid=0).
REQ-025 Maximum throughput SHALL be one beat per cycle within a frame; frame-to-frame overhead SHALL be 1 + IFG_CYCLES cycles.

Reset
REQ-026 async_resetn=0 SHALL immediately force state IDLE, grant=00, all tvalid/tready outputs 0, tx_axis_tdata/tkeep/tlast/tuser=0, beat counter 0, trunc_count 0, last-granted=requester 1.
REQ-027 Reset mid-frame SHALL abandon the frame without emitting a forced tlast; release SHALL be synchronous-deasserted by upstream logic.

Configuration
REQ-028 Macro ETH_TX_ARB_STRICT_PRIO_EN defined: requester 0 SHALL win whenever both are valid in IDLE; last-granted unused for arbitration.
REQ-029 Macro ETH_TX_ARB_STRICT_PRIO_EN undefined: round-robin per REQ-016.

Verification
REQ-030 After reset, both valid with 3-beat frames, tready=1 -> req0 frame first (grant=01), 2 GAP cycles + 1 arbitration cycle, then req1 (grant=10); repeat alternates.
REQ-031 req0 sends 200-beat frame, MAX_BEATS=191 -> 191 beats out, beat 191 has tlast=1,tuser=1; remaining 9 beats consumed with tx_axis_tvalid=0; trunc_count=1.
REQ-032 req0 sends exactly 191-beat frame -> unmodified, tuser=0, trunc_count=0.
REQ-033 tx_axis_tready toggled 1,0 per cycle during 4-beat frame -> exactly 4 beats accepted in order, owner tready mirrors tx_axis_tready, req1 tready stays 0.
REQ-034 async_resetn pulsed low at beat 2 of 5 -> all outputs 0 same cycle, grant=00, next request re-arbitrated from IDLE with req0 winning.
REQ-035 With ETH_TX_ARB_STRICT_PRIO_EN, req0 and req1 continuously valid -> req1 never granted.
